// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier: one partial product per cycle,
// signed operands handled by magnitude multiply plus a final negate.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] ZHi
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e             state_q,  state_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic               neg_q,    neg_d;
  logic               done_q,   done_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    done_d   = 1'b0;

    // Upper half plus the selected partial product; the carry is bit WIDTH.
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
          mcand_d  = (isSigned && X[WIDTH-1]) ? -X : X;
          mplier_d = (isSigned && Y[WIDTH-1]) ? -Y : Y;
          neg_d    = isSigned & (X[WIDTH-1] ^ Y[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        prod_d  = neg_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register, datapath included, is cleared by reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == FIX);
  assign done = done_q;
  assign Z    = prod_q[WIDTH-1:0];
  assign ZHi  = prod_q[2*WIDTH-1:WIDTH];

endmodule
